mips_exec_unit: RTL and testbench

Combined decode/execute/latch block for the 5-stage MIPS pipeline. It decodes opcode/funct into pipeline control bits, applies the ALU to the operands, and captures the results into the EX/MEM pipeline register that feeds the memory stage. Control decode and ALU are combinational; every output is registered.

---
 rtl/mips_exec_if.sv | 38 +++
 rtl/mips_exec_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_mips_exec_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_exec_if.sv
// Operand/control bus between the decode stage and the EX/MEM latch of mips_exec_unit.
interface mips_exec_if;
  logic        en;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] imm;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] branch_target;

  logic        mem_write;
  logic        mem_read;
  logic        branch;
  logic        jump;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] pc_out;
  logic [31:0] alu_result;
  logic [2:0]  alu_sign;
  logic [31:0] mem_wdata;
  logic [4:0]  reg_waddr;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output en, opcode, funct, rdata1, rdata2, imm, rt_addr, rd_addr, branch_target,
    input  mem_write, mem_read, branch, jump, mem_to_reg, reg_write,
           pc_out, alu_result, alu_sign, mem_wdata, reg_waddr, hi, lo
  );

  modport slave (
    input  en, opcode, funct, rdata1, rdata2, imm, rt_addr, rd_addr, branch_target,
    output mem_write, mem_read, branch, jump, mem_to_reg, reg_write,
           pc_out, alu_result, alu_sign, mem_wdata, reg_waddr, hi, lo
  );
endinterface

// File: rtl/mips_exec_unit.sv
// MIPS decode + ALU + EX/MEM pipeline register; all outputs registered.
// Define MIPS_EXEC_MULT_EN to enable MULT/MULTU and the hi/lo product registers.
module mips_exec_unit (
  input  logic         clk,
  input  logic         reset,
  mips_exec_if.slave   bus
);

  localparam int unsigned DataW = 32;
  localparam int unsigned RegAw = 5;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_MULT  = 5'd13,
    OP_MULTU = 5'd14,
    OP_LUI   = 5'd15,
    OP_NONE  = 5'd31
  } alu_op_e;

  // Decoded controls
  alu_op_e alu_op;
  logic    alu_src_b, reg_dst;
  logic    dec_mem_write, dec_mem_read, dec_branch, dec_jump, dec_mem_to_reg, dec_reg_write;

  // Instruction decode
  always_comb begin
    alu_op         = OP_NONE;
    alu_src_b      = 1'b0;
    reg_dst        = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    unique case (bus.opcode)
      6'h00: begin
        reg_dst       = 1'b1;
        dec_reg_write = 1'b1;
        case (bus.funct)
          6'h20: alu_op = OP_ADD;
          6'h21: alu_op = OP_ADDU;
          6'h22: alu_op = OP_SUB;
          6'h23: alu_op = OP_SUBU;
          6'h24: alu_op = OP_AND;
          6'h25: alu_op = OP_OR;
          6'h26: alu_op = OP_XOR;
          6'h27: alu_op = OP_NOR;
          6'h2A: alu_op = OP_SLT;
          6'h2B: alu_op = OP_SLTU;
          6'h04: alu_op = OP_SLL;
          6'h06: alu_op = OP_SRL;
          6'h07: alu_op = OP_SRA;
`ifdef MIPS_EXEC_MULT_EN
          6'h18: begin alu_op = OP_MULT;  dec_reg_write = 1'b0; end
          6'h19: begin alu_op = OP_MULTU; dec_reg_write = 1'b0; end
`endif
          default: begin
            reg_dst       = 1'b0;
            dec_reg_write = 1'b0;
            alu_op        = OP_NONE;
          end
        endcase
      end
      6'h08: begin alu_op = OP_ADD;  alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h09: begin alu_op = OP_ADDU; alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0A: begin alu_op = OP_SLT;  alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0B: begin alu_op = OP_SLTU; alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0C: begin alu_op = OP_AND;  alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0D: begin alu_op = OP_OR;   alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0E: begin alu_op = OP_XOR;  alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h0F: begin alu_op = OP_LUI;  alu_src_b = 1'b1; dec_reg_write = 1'b1; end
      6'h23: begin
        alu_op         = OP_ADDU;
        alu_src_b      = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      6'h2B: begin
        alu_op        = OP_ADDU;
        alu_src_b     = 1'b1;
        dec_mem_write = 1'b1;
      end
      6'h04: begin alu_op = OP_SUB; dec_branch = 1'b1; end
      6'h02: dec_jump = 1'b1;
      default: ;
    endcase
  end

  // ALU
  logic [DataW-1:0] op_a, op_b, sum, diff, alu_res;
  logic             alu_over, alu_zero;

  assign op_a = bus.rdata1;
  assign op_b = alu_src_b ? bus.imm : bus.rdata2;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res  = '0;
    alu_over = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        alu_res  = sum;
        alu_over = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res  = diff;
        alu_over = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {31'b0, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {31'b0, (op_a < op_b)};
      OP_SLL:  alu_res = op_b << op_a[4:0];
      OP_SRL:  alu_res = op_b >> op_a[4:0];
      OP_SRA:  alu_res = DataW'($signed(op_b) >>> op_a[4:0]);
      OP_LUI:  alu_res = {op_b[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // EX/MEM register
  logic             mem_write_q, mem_read_q, branch_q, jump_q, mem_to_reg_q, reg_write_q;
  logic             mem_write_d, mem_read_d, branch_d, jump_d, mem_to_reg_d, reg_write_d;
  logic [DataW-1:0] pc_q, pc_d, alu_result_q, alu_result_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]       alu_sign_q, alu_sign_d;
  logic [RegAw-1:0] reg_waddr_q, reg_waddr_d;

  always_comb begin
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    pc_d         = pc_q;
    alu_result_d = alu_result_q;
    alu_sign_d   = alu_sign_q;
    mem_wdata_d  = mem_wdata_q;
    reg_waddr_d  = reg_waddr_q;
    if (bus.en) begin
      mem_write_d  = dec_mem_write;
      mem_read_d   = dec_mem_read;
      branch_d     = dec_branch;
      jump_d       = dec_jump;
      mem_to_reg_d = dec_mem_to_reg;
      reg_write_d  = dec_reg_write;
      pc_d         = bus.branch_target;
      alu_result_d = alu_res;
      alu_sign_d   = {alu_zero, alu_over, alu_res[31]};
      mem_wdata_d  = bus.rdata2;
      reg_waddr_d  = reg_dst ? bus.rd_addr : bus.rt_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_q         <= '0;
      alu_result_q <= '0;
      alu_sign_q   <= '0;
      mem_wdata_q  <= '0;
      reg_waddr_q  <= '0;
    end else begin
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      pc_q         <= pc_d;
      alu_result_q <= alu_result_d;
      alu_sign_q   <= alu_sign_d;
      mem_wdata_q  <= mem_wdata_d;
      reg_waddr_q  <= reg_waddr_d;
    end
  end

`ifdef MIPS_EXEC_MULT_EN
  // One shared 64x64 multiplier; sign extension of the operands selects MULT vs MULTU
  logic [63:0] mul_a, mul_b, product;
  logic        mul_signed;
  logic [DataW-1:0] hi_q, hi_d, lo_q, lo_d;

  assign mul_signed = (alu_op == OP_MULT);
  assign mul_a      = {{32{mul_signed & op_a[31]}}, op_a};
  assign mul_b      = {{32{mul_signed & op_b[31]}}, op_b};
  assign product    = mul_a * mul_b;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.en && (alu_op == OP_MULT || alu_op == OP_MULTU)) begin
      hi_d = product[63:32];
      lo_d = product[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
`else
  assign bus.hi = '0;
  assign bus.lo = '0;
`endif

  assign bus.mem_write  = mem_write_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.branch     = branch_q;
  assign bus.jump       = jump_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.pc_out     = pc_q;
  assign bus.alu_result = alu_result_q;
  assign bus.alu_sign   = alu_sign_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.reg_waddr  = reg_waddr_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed-vector bench for mips_exec_unit; MULT checks follow MIPS_EXEC_MULT_EN.
module tb_mips_exec_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mips_exec_if bus ();

  mips_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] bt);
    bus.opcode        = op;
    bus.funct         = fn;
    bus.rdata1        = a;
    bus.rdata2        = b;
    bus.imm           = im;
    bus.rt_addr       = rt;
    bus.rd_addr       = rd;
    bus.branch_target = bt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res"},  bus.alu_result, 32'h0);
    check({tag, "_pc"},   bus.pc_out, 32'h0);
    check({tag, "_ctl"},  {26'b0, bus.mem_write, bus.mem_read, bus.branch, bus.jump,
                           bus.mem_to_reg, bus.reg_write}, 32'h0);
    check({tag, "_misc"}, {24'b0, bus.alu_sign, bus.reg_waddr}, 32'h0);
    check({tag, "_wd"},   bus.mem_wdata, 32'h0);
  endtask

  initial begin
    reset  = 1'b1;
    bus.en = 1'b1;
    drive(6'h00, 6'h20, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 32'h44);
    step();
    step();
    check_all_zero("rst_hold");

    // ADD with signed overflow
    reset = 1'b0;
    drive(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd3, 5'd7, 32'h1234);
    step();
    check("add_res",   bus.alu_result, 32'h80000000);
    check("add_sign",  {29'b0, bus.alu_sign}, 32'h3);
    check("add_rw",    {31'b0, bus.reg_write}, 32'h1);
    check("add_waddr", {27'b0, bus.reg_waddr}, 32'd7);
    check("add_pc",    bus.pc_out, 32'h1234);

    // Asynchronous reset mid-cycle, then inputs toggle with en=1
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    drive(6'h23, 6'h00, 32'h100, 32'h55, 32'h4, 5'd9, 5'd10, 32'h88);
    step();
    drive(6'h2B, 6'h00, 32'h200, 32'h66, 32'h8, 5'd4, 5'd5, 32'h99);
    step();
    check_all_zero("rst_en");
    reset = 1'b0;

    // beq taken
    drive(6'h04, 6'h00, 32'h5, 32'h5, 32'h0, 5'd1, 5'd2, 32'h40);
    step();
    check("beq_res",  bus.alu_result, 32'h0);
    check("beq_sign", {29'b0, bus.alu_sign}, 32'h4);
    check("beq_br",   {31'b0, bus.branch}, 32'h1);
    check("beq_pc",   bus.pc_out, 32'h40);
    check("beq_rw",   {31'b0, bus.reg_write}, 32'h0);

    // lw
    drive(6'h23, 6'h00, 32'h100, 32'h0, 32'hFFFFFFFC, 5'd9, 5'd17, 32'h0);
    step();
    check("lw_res",   bus.alu_result, 32'hFC);
    check("lw_ctl",   {29'b0, bus.mem_read, bus.mem_to_reg, bus.reg_write}, 32'h7);
    check("lw_waddr", {27'b0, bus.reg_waddr}, 32'd9);
    check("lw_mw",    {31'b0, bus.mem_write}, 32'h0);

    // sw
    drive(6'h2B, 6'h00, 32'h200, 32'hDEADBEEF, 32'h8, 5'd4, 5'd5, 32'h0);
    step();
    check("sw_res",  bus.alu_result, 32'h208);
    check("sw_mw",   {31'b0, bus.mem_write}, 32'h1);
    check("sw_wd",   bus.mem_wdata, 32'hDEADBEEF);
    check("sw_ctl",  {30'b0, bus.mem_read, bus.reg_write}, 32'h0);

    // SUB overflow, SUBU never overflows
    drive(6'h00, 6'h22, 32'h80000000, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("sub_res",  bus.alu_result, 32'h7FFFFFFF);
    check("sub_sign", {29'b0, bus.alu_sign}, 32'h2);
    drive(6'h00, 6'h23, 32'h80000000, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("subu_res",  bus.alu_result, 32'h7FFFFFFF);
    check("subu_sign", {29'b0, bus.alu_sign}, 32'h0);

    // SLT vs SLTU on -1 < 1
    drive(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("slt_res", bus.alu_result, 32'h1);
    drive(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("sltu_res",  bus.alu_result, 32'h0);
    check("sltu_sign", {29'b0, bus.alu_sign}, 32'h4);

    // Variable shifts use only A[4:0]
    drive(6'h00, 6'h07, 32'h4, 32'h80000000, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("srav_res",  bus.alu_result, 32'hF8000000);
    check("srav_sign", {29'b0, bus.alu_sign}, 32'h1);
    drive(6'h00, 6'h04, 32'h24, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("sllv_res", bus.alu_result, 32'h10);
    drive(6'h00, 6'h06, 32'h1F, 32'h80000000, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("srlv_res", bus.alu_result, 32'h1);

    // LUI and NOR
    drive(6'h0F, 6'h00, 32'h0, 32'hFFFF, 32'h00001234, 5'd12, 5'd13, 32'h0);
    step();
    check("lui_res",   bus.alu_result, 32'h12340000);
    check("lui_waddr", {27'b0, bus.reg_waddr}, 32'd12);
    drive(6'h00, 6'h27, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("nor_res", bus.alu_result, 32'hFFFFFFFF);

    // Unknown funct, flush opcode, jump
    drive(6'h00, 6'h3F, 32'h7, 32'h9, 32'h0, 5'd6, 5'd8, 32'h0);
    step();
    check("unk_res",  bus.alu_result, 32'h0);
    check("unk_rw",   {31'b0, bus.reg_write}, 32'h0);
    check("unk_sign", {29'b0, bus.alu_sign}, 32'h4);
    drive(6'h3F, 6'h20, 32'h7, 32'h9, 32'h9, 5'd6, 5'd8, 32'h0);
    step();
    check("flush_ctl", {26'b0, bus.mem_write, bus.mem_read, bus.branch, bus.jump,
                        bus.mem_to_reg, bus.reg_write}, 32'h0);
    drive(6'h02, 6'h00, 32'h0, 32'h0, 32'h0, 5'd6, 5'd8, 32'h400);
    step();
    check("j_ctl", {26'b0, bus.mem_write, bus.mem_read, bus.branch, bus.jump,
                    bus.mem_to_reg, bus.reg_write}, 32'h4);

    // Hold with en=0 for three cycles
    drive(6'h09, 6'h00, 32'hA, 32'h0, 32'h5, 5'd21, 5'd22, 32'h500);
    step();
    check("addiu_res", bus.alu_result, 32'hF);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'h2B, 6'h00, 32'h1000 + i, 32'hCAFE0000 + i, 32'h10, 5'd1, 5'd2, 32'h900);
      step();
      check("hold_res",  bus.alu_result, 32'hF);
      check("hold_ctl",  {25'b0, bus.mem_write, bus.reg_write, bus.reg_waddr}, {25'b0, 2'b01, 5'd21});
      check("hold_pc",   bus.pc_out, 32'h500);
    end
    bus.en = 1'b1;
    drive(6'h0D, 6'h00, 32'hF0, 32'h0, 32'h0F, 5'd23, 5'd24, 32'h600);
    step();
    check("resume_res", bus.alu_result, 32'hFF);
    check("resume_pc",  bus.pc_out, 32'h600);

`ifdef MIPS_EXEC_MULT_EN
    drive(6'h00, 6'h18, 32'hFFFFFFFE, 32'h3, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("mult_hi",  bus.hi, 32'hFFFFFFFF);
    check("mult_lo",  bus.lo, 32'hFFFFFFFA);
    check("mult_rw",  {31'b0, bus.reg_write}, 32'h0);
    check("mult_res", bus.alu_result, 32'h0);
    drive(6'h00, 6'h19, 32'hFFFFFFFE, 32'h3, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("multu_hi", bus.hi, 32'h2);
    check("multu_lo", bus.lo, 32'hFFFFFFFA);
    drive(6'h00, 6'h20, 32'h1, 32'h1, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("hilo_keep_hi", bus.hi, 32'h2);
    check("hilo_keep_lo", bus.lo, 32'hFFFFFFFA);
    bus.en = 1'b0;
    drive(6'h00, 6'h18, 32'h5, 32'h5, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("hilo_hold_lo", bus.lo, 32'hFFFFFFFA);
    bus.en = 1'b1;
`else
    drive(6'h00, 6'h18, 32'hFFFFFFFE, 32'h3, 32'h0, 5'd1, 5'd2, 32'h0);
    step();
    check("nomult_hi",  bus.hi, 32'h0);
    check("nomult_lo",  bus.lo, 32'h0);
    check("nomult_rw",  {31'b0, bus.reg_write}, 32'h0);
    check("nomult_wa",  {27'b0, bus.reg_waddr}, 32'd1);
    check("nomult_res", bus.alu_result, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
